retire_stage: RTL and testbench

//  In-order commit stage directly downstream of the ROB. Each cycle inspects the N oldest ROB entries,

---
 rtl/retire_stage_pkg.sv | 37 +++
 rtl/retire_stage_prefix.sv | 35 +++
 rtl/retire_stage.sv | 159 +++++++++++++++
 tb/tb_retire_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/retire_stage_pkg.sv
// Shared types and sizing for the in-order retire stage.
package retire_stage_pkg;

    localparam int N         = 3;                   // retire width, equals ROB read width
    localparam int ARCH_REGS = 32;                  // architectural registers, x0 never mapped
    localparam int PHYS_REGS = 64;                  // physical registers
    localparam int PR_BITS   = $clog2(PHYS_REGS);   // physical register tag width
    localparam int AR_BITS   = $clog2(ARCH_REGS);   // architectural register index width
    localparam int CNT_BITS  = $clog2(N + 1);       // width of a 0..N retire count

    // One ROB entry as seen by the retire stage (first field is the MSB).
    typedef struct packed {
        logic               complete;
        logic               has_dest;
        logic [AR_BITS-1:0] dest_arch;
        logic [PR_BITS-1:0] t_new;
        logic [PR_BITS-1:0] t_old;
        logic               mispred;
        logic               halt;
    } rob_exit_packet_t;

    localparam int PKT_W = $bits(rob_exit_packet_t);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } retire_state_t;

    // Add a retire count to the running total, pinning at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [CNT_BITS-1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {{(33 - CNT_BITS){1'b0}}, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/retire_stage_prefix.sv
// Finds the longest in-order run of retirable ROB head entries.
// A slot is retirable when it exists and is complete; the run ends at the
// first slot that is not retirable, and also ends right after (inclusive)
// a slot that carries a redirect (mispredict or halt).
module retire_prefix
    import retire_stage_pkg::*;
(
    input  logic [N-1:0]        valid_i,
    input  logic [N-1:0]        complete_i,
    input  logic [N-1:0]        stop_i,
    output logic [CNT_BITS-1:0] count_o,
    output logic [N-1:0]        mask_o
);

    logic open;

    // Walk from oldest to youngest, extending the retire group while it stays unbroken.
    always_comb begin
        mask_o  = '0;
        count_o = '0;
        open    = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (open && valid_i[i] && complete_i[i]) begin
                mask_o[i] = 1'b1;
                count_o   = count_o + CNT_BITS'(1);
                if (stop_i[i]) begin
                    open = 1'b0;
                end
            end else begin
                open = 1'b0;
            end
        end
    end

endmodule

// File: rtl/retire_stage.sv
// In-order commit stage: retires the complete prefix of the ROB head,
// updates the architectural map, returns stale physical registers to the
// free list, and sequences flush/halt after redirecting instructions.
module retire_stage
    import retire_stage_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N*PKT_W-1:0]           rob_head,
    input  logic [N-1:0]                 rob_head_valid,
    output logic [CNT_BITS-1:0]          retire_cnt,
    output logic [N-1:0]                 free_valid,
    output logic [N*PR_BITS-1:0]         free_preg,
    output logic [ARCH_REGS*PR_BITS-1:0] arch_map,
    output logic                         flush,
    output logic                         halted,
    output logic [31:0]                  retired_total
);

    rob_exit_packet_t    pkt [N];
    logic [N-1:0]        complete_v;
    logic [N-1:0]        stop_v;
    logic [N-1:0]        mispred_v;
    logic [N-1:0]        halt_v;
    logic [N-1:0]        writes_v;

    logic [CNT_BITS-1:0] prefix_cnt;
    logic [N-1:0]        prefix_mask;
    logic                retire_en;
    logic [N-1:0]        retire_mask;
    logic                mispred_hit;
    logic                halt_hit;

    retire_state_t       state_q;
    retire_state_t       state_d;

    logic [PR_BITS-1:0]  map_q [ARCH_REGS];
    logic [PR_BITS-1:0]  map_d [ARCH_REGS];
    logic                flush_q;
    logic                halted_q;
    logic [31:0]         total_q;

    // Split the flat head bus into per-slot packets and per-slot flag vectors.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            pkt[i]        = rob_head[i*PKT_W +: PKT_W];
            complete_v[i] = pkt[i].complete;
            mispred_v[i]  = pkt[i].mispred;
            halt_v[i]     = pkt[i].halt;
            stop_v[i]     = pkt[i].mispred | pkt[i].halt;
            writes_v[i]   = pkt[i].has_dest && (pkt[i].dest_arch != '0);
        end
    end

    retire_prefix u_prefix (
        .valid_i    (rob_head_valid),
        .complete_i (complete_v),
        .stop_i     (stop_v),
        .count_o    (prefix_cnt),
        .mask_o     (prefix_mask)
    );

    // Retirement only happens in RUN and never while reset is held.
    always_comb begin
        retire_en   = reset && (state_q == RUN);
        retire_mask = retire_en ? prefix_mask : '0;
        mispred_hit = |(retire_mask & mispred_v);
        halt_hit    = |(retire_mask & halt_v);
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a retired halt outranks a retired mispredict.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (halt_hit) begin
                    state_d = HALTED;
                end else if (mispred_hit) begin
                    state_d = FLUSH;
                end
            end
            FLUSH:   state_d = RUN;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // Same-cycle retire outputs: pop count and freed stale registers.
    always_comb begin
        retire_cnt = retire_en ? prefix_cnt : '0;
        free_valid = retire_mask & writes_v;
        free_preg  = '0;
        for (int i = 0; i < N; i++) begin
            if (free_valid[i]) begin
                free_preg[i*PR_BITS +: PR_BITS] = pkt[i].t_old;
            end
        end
    end

    // Map update in age order so the youngest writer of a register lands last.
    always_comb begin
        for (int r = 0; r < ARCH_REGS; r++) begin
            map_d[r] = map_q[r];
        end
        for (int i = 0; i < N; i++) begin
            if (retire_mask[i] && writes_v[i]) begin
                map_d[pkt[i].dest_arch] = pkt[i].t_new;
            end
        end
    end

    // Architectural map: identity after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < ARCH_REGS; r++) begin
                map_q[r] <= PR_BITS'(r);
            end
        end else begin
            for (int r = 0; r < ARCH_REGS; r++) begin
                map_q[r] <= map_d[r];
            end
        end
    end

    // Registered status flags and saturating retired-instruction count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
            total_q  <= '0;
        end else begin
            flush_q  <= (state_d == FLUSH);
            halted_q <= (state_d == HALTED);
            total_q  <= sat_add32(total_q, retire_cnt);
        end
    end

    // Present the registered map as a flat recovery bus.
    always_comb begin
        arch_map = '0;
        for (int r = 0; r < ARCH_REGS; r++) begin
            arch_map[r*PR_BITS +: PR_BITS] = map_q[r];
        end
    end

    assign flush         = flush_q;
    assign halted        = halted_q;
    assign retired_total = total_q;

endmodule

// File: tb/tb_retire_stage.sv
// Scoreboard bench for retire_stage: directed scenarios followed by random ROB heads.
module tb_retire_stage;
    import retire_stage_pkg::*;

    logic                         clock;
    logic                         reset;
    logic [N*PKT_W-1:0]           rob_head;
    logic [N-1:0]                 rob_head_valid;
    logic [CNT_BITS-1:0]          retire_cnt;
    logic [N-1:0]                 free_valid;
    logic [N*PR_BITS-1:0]         free_preg;
    logic [ARCH_REGS*PR_BITS-1:0] arch_map;
    logic                         flush;
    logic                         halted;
    logic [31:0]                  retired_total;

    retire_stage dut (
        .clock          (clock),
        .reset          (reset),
        .rob_head       (rob_head),
        .rob_head_valid (rob_head_valid),
        .retire_cnt     (retire_cnt),
        .free_valid     (free_valid),
        .free_preg      (free_preg),
        .arch_map       (arch_map),
        .flush          (flush),
        .halted         (halted),
        .retired_total  (retired_total)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [CNT_BITS-1:0]          cnt;
        logic [N-1:0]                 fv;
        logic [N*PR_BITS-1:0]         fp;
        logic                         fl;
        logic                         hl;
        logic [31:0]                  tot;
        logic [ARCH_REGS*PR_BITS-1:0] map;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: the architectural view, not the RTL's encoding.
    rob_exit_packet_t cur_pk [N];
    logic [N-1:0]     cur_vld;
    int               m_map [ARCH_REGS];
    bit               m_flush;
    bit               m_halted;
    longint           m_total;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic rob_exit_packet_t mk(input logic c, input logic hd, input int d,
                                            input int tn, input int to, input logic m, input logic h);
        rob_exit_packet_t p;
        p.complete  = c;
        p.has_dest  = hd;
        p.dest_arch = AR_BITS'(d);
        p.t_new     = PR_BITS'(tn);
        p.t_old     = PR_BITS'(to);
        p.mispred   = m;
        p.halt      = h;
        return p;
    endfunction

    task automatic clear_heads();
        cur_vld = '0;
        for (int i = 0; i < N; i++) cur_pk[i] = '0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < ARCH_REGS; r++) m_map[r] = r;
        m_flush  = 0;
        m_halted = 0;
        m_total  = 0;
    endtask

    // Number of oldest entries that may commit: complete, present, stopping after a redirect.
    function automatic int model_k();
        int n = 0;
        while (n < N && cur_vld[n] && cur_pk[n].complete) begin
            n++;
            if (cur_pk[n-1].mispred || cur_pk[n-1].halt) break;
        end
        return n;
    endfunction

    // One clock cycle: drive heads, predict the visible outputs, then advance the model.
    task automatic step(input logic rst_v);
        exp_t e;
        int   k;
        bit   mh;
        bit   hh;
        @(negedge clock);
        reset = rst_v;
        for (int i = 0; i < N; i++) rob_head[i*PKT_W +: PKT_W] = cur_pk[i];
        rob_head_valid = cur_vld;
        if (!rst_v) model_reset();
        k = 0;
        if (rst_v && !m_halted && !m_flush) k = model_k();
        e.cnt = CNT_BITS'(k);
        e.fv  = '0;
        e.fp  = '0;
        mh = 0;
        hh = 0;
        for (int i = 0; i < k; i++) begin
            mh |= cur_pk[i].mispred;
            hh |= cur_pk[i].halt;
            if (cur_pk[i].has_dest && cur_pk[i].dest_arch != 0) begin
                e.fv[i] = 1'b1;
                e.fp[i*PR_BITS +: PR_BITS] = cur_pk[i].t_old;
            end
        end
        e.fl  = m_flush;
        e.hl  = m_halted;
        e.tot = m_total[31:0];
        for (int r = 0; r < ARCH_REGS; r++) e.map[r*PR_BITS +: PR_BITS] = PR_BITS'(m_map[r]);
        sbq.push_back(e);
        if (rst_v) begin
            for (int i = 0; i < k; i++)
                if (cur_pk[i].has_dest && cur_pk[i].dest_arch != 0)
                    m_map[cur_pk[i].dest_arch] = cur_pk[i].t_new;
            m_total = m_total + k;
            if (m_total > 64'h0000_0000_FFFF_FFFF) m_total = 64'h0000_0000_FFFF_FFFF;
            m_halted = m_halted || hh;
            m_flush  = mh && !hh;
        end
    endtask

    // Monitor: every cycle the DUT presents a result, compare it with the oldest prediction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("retire_cnt",    retire_cnt,    e.cnt);
                chk("free_valid",    free_valid,    e.fv);
                chk("free_preg",     free_preg,     e.fp);
                chk("flush",         flush,         e.fl);
                chk("halted",        halted,        e.hl);
                chk("retired_total", retired_total, e.tot);
                chk("arch_map",      arch_map,      e.map);
            end
        end
    end

    initial begin : stimulus
        reset          = 1'b0;
        rob_head       = '0;
        rob_head_valid = '0;
        clear_heads();
        model_reset();

        // Reset held, then released with no valid heads.
        step(0);
        step(0);
        step(1);
        step(1);

        // Three complete writers x3/x4/x5.
        cur_pk[0] = mk(1, 1, 3, 40, 3, 0, 0);
        cur_pk[1] = mk(1, 1, 4, 41, 4, 0, 0);
        cur_pk[2] = mk(1, 1, 5, 42, 5, 0, 0);
        cur_vld   = 3'b111;
        step(1);
        clear_heads();
        step(1);

        // Incomplete middle slot blocks younger complete slot.
        cur_pk[0] = mk(1, 1, 8, 20, 9, 0, 0);
        cur_pk[1] = mk(0, 1, 9, 21, 10, 0, 0);
        cur_pk[2] = mk(1, 1, 10, 22, 11, 0, 0);
        cur_vld   = 3'b111;
        step(1);

        // Hole in the valid vector stops retirement.
        cur_pk[1] = mk(1, 1, 9, 21, 10, 0, 0);
        cur_vld   = 3'b101;
        step(1);

        // Mispredict in slot 1: two retire, then one flush cycle.
        cur_pk[0] = mk(1, 1, 11, 30, 12, 0, 0);
        cur_pk[1] = mk(1, 0, 12, 31, 13, 1, 0);
        cur_pk[2] = mk(1, 1, 13, 32, 14, 0, 0);
        cur_vld   = 3'b111;
        step(1);
        cur_pk[1] = mk(1, 1, 12, 31, 13, 0, 0);
        step(1);
        step(1);

        // Two writers of x7, one write to x0 in between.
        cur_pk[0] = mk(1, 1, 7, 50, 17, 0, 0);
        cur_pk[1] = mk(1, 1, 0, 51, 18, 0, 0);
        cur_pk[2] = mk(1, 1, 7, 52, 19, 0, 0);
        cur_vld   = 3'b111;
        step(1);
        clear_heads();
        step(1);

        // Halt and mispredict on the same entry: halt wins, no flush.
        cur_pk[0] = mk(1, 1, 6, 60, 6, 1, 1);
        cur_pk[1] = mk(1, 1, 2, 61, 2, 0, 0);
        cur_pk[2] = mk(1, 1, 1, 62, 1, 0, 0);
        cur_vld   = 3'b111;
        step(1);
        cur_pk[0] = mk(1, 1, 6, 60, 6, 0, 0);
        step(1);
        step(1);
        step(1);
        step(0);
        step(1);

        // Random heads with occasional resets to escape halt.
        clear_heads();
        for (int c = 0; c < 800; c++) begin
            int n;
            logic rv;
            n = $urandom_range(0, 3);
            cur_vld = N'((1 << n) - 1);
            if ($urandom_range(0, 7) == 0) cur_vld = N'($urandom);
            for (int i = 0; i < N; i++) begin
                cur_pk[i] = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                               $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63),
                               $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
            end
            rv = 1'b1;
            if (m_halted && $urandom_range(0, 5) == 0) rv = 1'b0;
            if ($urandom_range(0, 149) == 0) rv = 1'b0;
            step(rv);
        end

        @(negedge clock);
        #4;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
